// File: rtl/lcd_char_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : lcd_char_responder_pkg                                         |
// | Purpose   : Shared constants for the LCD character responder: bus control  |
// |             bit positions, the blank character, FSM state encodings and    |
// |             the instruction-byte classifier.                               |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package lcd_char_responder_pkg;

    // lcd_ctrl bit positions
    localparam int c_RS_BIT = 0;    // 0 = instruction, 1 = data
    localparam int c_RW_BIT = 1;    // 0 = write, 1 = read

    localparam logic [7:0] c_CHAR_SPACE = 8'h20;

    // FSM state encodings
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CLEAR = 2'd1;
    localparam logic [1:0] c_ST_BUSY  = 2'd2;

    // Instruction classes
    localparam logic [2:0] c_OP_NOP    = 3'd0;  // 0x00 and function set
    localparam logic [2:0] c_OP_SET_AC = 3'd1;  // 1aaaaaaa
    localparam logic [2:0] c_OP_SHIFT  = 3'd2;  // 0001 S/C R/L xx
    localparam logic [2:0] c_OP_DISP   = 3'd3;  // 00001DCB
    localparam logic [2:0] c_OP_ENTRY  = 3'd4;  // 000001 I/D S
    localparam logic [2:0] c_OP_HOME   = 3'd5;  // 0000001x
    localparam logic [2:0] c_OP_CLEAR  = 3'd6;  // 00000001

    // Highest set bit of the instruction byte selects the instruction.
    function automatic logic [2:0] decode_instr(input logic [7:0] d);
        logic [2:0] op;
        op = c_OP_NOP;
        casez (d)
            8'b1???_????: op = c_OP_SET_AC;
            8'b001?_????: op = c_OP_NOP;
            8'b0001_????: op = c_OP_SHIFT;
            8'b0000_1???: op = c_OP_DISP;
            8'b0000_01??: op = c_OP_ENTRY;
            8'b0000_001?: op = c_OP_HOME;
            8'b0000_0001: op = c_OP_CLEAR;
            default:      op = c_OP_NOP;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_char_responder_ddram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : lcd_char_responder_ddram                                       |
// | Purpose   : Character RAM, 2**AW x 8. One synchronous write port and two   |
// |             synchronous read ports. A read of the address being written in |
// |             the same cycle returns the old byte.                           |
// | Ports     : clk                 clock                                      |
// |             i_we/i_waddr/i_wdata write port                                |
// |             i_raddr_a/o_rdata_a  bus read port (1-cycle latency)           |
// |             i_raddr_b/o_rdata_b  view read port (1-cycle latency)          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module lcd_char_responder_ddram #(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [7:0]    o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [7:0]    o_rdata_b
);

    localparam int c_DEPTH = 1 << AW;

    logic [7:0] r_mem [0:c_DEPTH-1];
    logic [7:0] r_rdata_a;
    logic [7:0] r_rdata_b;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata_a <= r_mem[i_raddr_a];
        r_rdata_b <= r_mem[i_raddr_b];
    end

    assign o_rdata_a = r_rdata_a;
    assign o_rdata_b = r_rdata_b;

endmodule
`default_nettype wire

// File: rtl/lcd_char_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : lcd_char_responder                                             |
// | Purpose   : LCD-side endpoint of the lcd_data/lcd_ctrl/lcd_enable bus.     |
// |             Decodes an HD44780-style instruction subset, keeps DDRAM and   |
// |             the address counter, and offers busy/AC readback plus a view   |
// |             port for a renderer.                                           |
// | Ports     : clk, rst            clock, synchronous active-high reset       |
// |             lcd_data[7:0]       instruction / data byte                    |
// |             lcd_ctrl[1:0]       [0]=RS, [1]=RW                             |
// |             lcd_enable          strobe, transfer commits on its fall       |
// |             lcd_rdata[7:0]      registered read data                       |
// |             busy                controller busy                            |
// |             disp_on/cursor_on/blink_on  display-control bits               |
// |             overrun             sticky: transfer arrived while busy        |
// |             view_addr/view_char DDRAM view port, 1-cycle latency           |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module lcd_char_responder
    import lcd_char_responder_pkg::*;
#(
    parameter int AW          = 7,      // DDRAM address width, at most 7
    parameter int BUSY_CYCLES = 20      // must be at least 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    lcd_data,
    input  logic [1:0]    lcd_ctrl,
    input  logic          lcd_enable,
    output logic [7:0]    lcd_rdata,
    output logic          busy,
    output logic          disp_on,
    output logic          cursor_on,
    output logic          blink_on,
    output logic          overrun,
    input  logic [AW-1:0] view_addr,
    output logic [7:0]    view_char
);

    localparam int                c_BCW       = (BUSY_CYCLES < 2) ? 1 : $clog2(BUSY_CYCLES + 1);
    localparam logic [c_BCW-1:0]  c_BUSY_LOAD = c_BCW'(BUSY_CYCLES);
    localparam logic [AW-1:0]     c_LAST_ADDR = {AW{1'b1}};

    logic [1:0]       r_state;
    logic             r_en_q;
    logic [AW-1:0]    r_clr_cnt;
    logic [c_BCW-1:0] r_busy_cnt;
    logic [AW-1:0]    r_ac;
    logic             r_id;
    logic             r_disp;
    logic             r_cursor;
    logic             r_blink;
    logic             r_overrun;
    logic [7:0]       r_rdata;

    logic             w_fall;
    logic             w_rs;
    logic             w_rw;
    logic             w_idle;
    logic             w_status_rd;
    logic [2:0]       w_op;
    logic [AW-1:0]    w_ac_inc;
    logic [AW-1:0]    w_ac_dec;
    logic [AW-1:0]    w_ac_next;
    logic [7:0]       w_status;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [7:0]       w_wdata;
    logic [7:0]       w_bus_q;

    assign w_fall      = r_en_q & ~lcd_enable;
    assign w_rs        = lcd_ctrl[c_RS_BIT];
    assign w_rw        = lcd_ctrl[c_RW_BIT];
    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_status_rd = w_rw & ~w_rs;
    assign w_op        = decode_instr(lcd_data);

    // AC arithmetic wraps naturally at AW bits
    assign w_ac_inc  = r_ac + AW'(1);
    assign w_ac_dec  = r_ac - AW'(1);
    assign w_ac_next = r_id ? w_ac_inc : w_ac_dec;

    // AC is zero-extended into the low seven status bits
    assign w_status = {~w_idle, 7'(r_ac)};

    // Single write port shared by the clear sweep and bus data writes;
    // the two never coincide because bus writes are only taken in IDLE.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_ac;
        w_wdata = lcd_data;
        if (r_state == c_ST_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_clr_cnt;
            w_wdata = c_CHAR_SPACE;
        end else if (w_fall && w_idle && !w_rw && w_rs) begin
            w_we = 1'b1;
        end
    end

    lcd_char_responder_ddram #(
        .AW (AW)
    ) u_ddram (
        .clk       (clk),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (r_ac),
        .o_rdata_a (w_bus_q),
        .i_raddr_b (view_addr),
        .o_rdata_b (view_char)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_CLEAR;
            r_en_q     <= 1'b0;
            r_clr_cnt  <= '0;
            r_busy_cnt <= '0;
            r_ac       <= '0;
            r_id       <= 1'b1;
            r_disp     <= 1'b0;
            r_cursor   <= 1'b0;
            r_blink    <= 1'b0;
            r_overrun  <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_en_q <= lcd_enable;

            // Read data follows the bus while the strobe is high
            if (lcd_enable && w_rw) begin
                if (!w_rs) begin
                    r_rdata <= w_status;
                end else if (w_idle) begin
                    r_rdata <= w_bus_q;
                end
            end

            if (w_fall && !w_idle && !w_status_rd) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                c_ST_CLEAR: begin
                    if (r_clr_cnt == c_LAST_ADDR) begin
                        r_state    <= c_ST_BUSY;
                        r_busy_cnt <= c_BUSY_LOAD;
                        r_ac       <= '0;
                        r_id       <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + AW'(1);
                    end
                end

                c_ST_BUSY: begin
                    if (r_busy_cnt <= c_BCW'(1)) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_busy_cnt <= r_busy_cnt - c_BCW'(1);
                    end
                end

                c_ST_IDLE: begin
                    if (w_fall && !w_status_rd) begin
                        r_state    <= c_ST_BUSY;
                        r_busy_cnt <= c_BUSY_LOAD;
                        if (w_rw || w_rs) begin
                            // data read or data write: step AC per I/D
                            r_ac <= w_ac_next;
                        end else begin
                            case (w_op)
                                c_OP_SET_AC: r_ac <= lcd_data[AW-1:0];
                                c_OP_SHIFT: begin
                                    // display shift (S/C=1) is not modelled
                                    if (!lcd_data[3]) begin
                                        r_ac <= lcd_data[2] ? w_ac_inc : w_ac_dec;
                                    end
                                end
                                c_OP_DISP: begin
                                    r_disp   <= lcd_data[2];
                                    r_cursor <= lcd_data[1];
                                    r_blink  <= lcd_data[0];
                                end
                                // S has no observable effect, only I/D is kept
                                c_OP_ENTRY:  r_id <= lcd_data[1];
                                c_OP_HOME:   r_ac <= '0;
                                c_OP_CLEAR: begin
                                    r_state   <= c_ST_CLEAR;
                                    r_clr_cnt <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                default: begin
                    r_state   <= c_ST_CLEAR;
                    r_clr_cnt <= '0;
                end
            endcase
        end
    end

    assign busy      = ~w_idle;
    assign disp_on   = r_disp;
    assign cursor_on = r_cursor;
    assign blink_on  = r_blink;
    assign overrun   = r_overrun;
    assign lcd_rdata = r_rdata;

endmodule
`default_nettype wire
